// File: rtl/vec_dot_accum.sv
// vec_dot_accum: signed dot-product accumulator over NUM_VECTORS packed vectors, one formatted result per sum.
// Optional VEC_DOT_ACCUM_SATURATE_EN clamps the shifted sum to the signed OUT_WIDTH range instead of wrapping.
module vec_dot_accum #(
  parameter int DATA_WIDTH  = 16,
  parameter int FETCH_WIDTH = 4,
  parameter int NUM_VECTORS = 8,
  parameter int ACC_WIDTH   = 40,
  parameter int OUT_WIDTH   = 32,
  parameter int SHIFT       = 0,
  localparam int AW = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] vec_data,
  input  logic                              vec_empty_n,
  output logic                              vec_deq,
  output logic [AW-1:0]                     weight_addr,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] weight_data,
  output logic [OUT_WIDTH-1:0]              result_data,
  input  logic                              result_full_n,
  output logic                              result_enq
);
  typedef enum logic {ACCUM, EMIT} state_t;
  state_t r_state, w_state_nxt;
  logic [AW-1:0] r_count;
  logic signed [ACC_WIDTH-1:0] r_acc, w_dot, w_shr;
  logic signed [2*DATA_WIDTH-1:0] w_prod [FETCH_WIDTH];
  logic [OUT_WIDTH-1:0] w_fmt;
  logic w_last;
  for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_mul
    assign w_prod[g] = $signed(vec_data[g*DATA_WIDTH +: DATA_WIDTH]) * $signed(weight_data[g*DATA_WIDTH +: DATA_WIDTH]);
  end
  always_comb begin
    w_dot = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) w_dot = w_dot + ACC_WIDTH'(w_prod[i]);
  end
  assign w_shr = r_acc >>> SHIFT;
`ifdef VEC_DOT_ACCUM_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] L_MAX = ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH-1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] L_MIN = ~L_MAX;
  assign w_fmt = (w_shr > L_MAX) ? OUT_WIDTH'(L_MAX) : (w_shr < L_MIN) ? OUT_WIDTH'(L_MIN) : OUT_WIDTH'(w_shr);
`else
  assign w_fmt = OUT_WIDTH'(w_shr);
`endif
  assign vec_deq     = rst_n && vec_empty_n && (r_state == ACCUM);
  assign weight_addr = r_count;
  assign w_last      = (r_count == AW'(NUM_VECTORS-1));
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ACCUM && vec_deq && w_last) w_state_nxt = EMIT;
    if (r_state == EMIT && result_full_n) w_state_nxt = ACCUM;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ACCUM;
      r_count     <= '0;
      r_acc       <= '0;
      result_enq  <= 1'b0;
      result_data <= '0;
    end else begin
      r_state    <= w_state_nxt;
      result_enq <= 1'b0;
      if (vec_deq) begin
        r_acc   <= (r_count == '0) ? w_dot : r_acc + w_dot;
        r_count <= w_last ? '0 : r_count + 1'b1;
      end
      if (r_state == EMIT && result_full_n) begin
        result_data <= w_fmt;
        result_enq  <= 1'b1;
      end
    end
  end
endmodule

// File: doc/vec_dot_accum.md
Name: vec_dot_accum

Overview:
- Downstream consumer of the packed-vector aggregation stage.
- Pops FETCH_WIDTH-wide packed activation vectors from the upstream FIFO and forms a signed dot product with a weight vector fetched by index.
- Accumulates NUM_VECTORS dot products, then scales, truncates or saturates the sum and enqueues one result word into the output FIFO.
- Serves as the MAC core of the conv/dense layers.

Parameters:
- DATA_WIDTH, 16: signed width of each activation/weight element.
- FETCH_WIDTH, 4: elements per packed vector.
- NUM_VECTORS, 8: vectors accumulated per result (>=1).
- ACC_WIDTH, 40: signed accumulator width.
- OUT_WIDTH, 32: result word width.
- SHIFT, 0: arithmetic right shift applied to the accumulator before output.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset, synchronous, active-low.
- vec_data, input, FETCH_WIDTH*DATA_WIDTH: packed activations; element i at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- vec_empty_n, input, 1: upstream FIFO non-empty.
- vec_deq, output, 1: pop upstream FIFO this cycle.
- weight_addr, output, $clog2(NUM_VECTORS) (min 1): index of the current vector within the sum.
- weight_data, input, FETCH_WIDTH*DATA_WIDTH: packed weights for weight_addr, valid in the same cycle.
- result_data, output, OUT_WIDTH: result word.
- result_full_n, input, 1: output FIFO not full.
- result_enq, output, 1: push result_data into the output FIFO.

Behaviour:
Reset (rst_n low at posedge):
- state=ACCUM, count=0, acc=0, result_enq=0, result_data=0.
- vec_deq=0 combinationally while rst_n is low.
- Reset mid-sum discards the partial sum. Reset during EMIT drops the pending result.

Arithmetic:
- dot = sum over i of signed(vec_i) * signed(w_i). Products are 2*DATA_WIDTH bits, sign-extended to ACC_WIDTH.
- acc wraps at ACC_WIDTH; no overflow detection on acc.

weight_addr:
- Equals the count register; purely combinational from state.

State ACCUM:
- vec_deq = rst_n && vec_empty_n && (state==ACCUM).
- On a deq edge: acc <= (count==0 ? dot : acc+dot).
- If count==NUM_VECTORS-1: count <= 0 and state <= EMIT. Otherwise count <= count+1.
- No deq → all state holds.

State EMIT:
- vec_deq=0.
- If result_full_n=1 at posedge: result_data <= fmt(acc), result_enq <= 1 for exactly one cycle, state <= ACCUM.
- Otherwise hold, result_enq stays 0, with no limit on wait time.

Outputs and timing:
- result_enq is registered and is 0 in every cycle not following an EMIT fire.
- result_data holds its value until the next fire.
- fmt(x) = OUT_WIDTH LSBs of (x >>> SHIFT).
- Latency: last vector deq at edge t → result_enq high in cycle after edge t+1 (if full_n was high).
- Peak throughput: one result per NUM_VECTORS+1 cycles.
- NUM_VECTORS=1: every deq goes directly to EMIT.
- Simultaneous full_n drop in EMIT and vec arrival: EMIT has priority; no vector is consumed until the result is pushed.

Optional Feature:
Macro: VEC_DOT_ACCUM_SATURATE_EN
- Defined: fmt clamps (acc >>> SHIFT) to the signed OUT_WIDTH range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] before output.
- Undefined: plain truncation (two's-complement wrap).
- Timing and handshake are identical either way.

Test Plan:
1. All 8 vectors with activations=1, weights=2 (all elements), result_full_n=1 → exactly one result_enq pulse. result_data=64. weight_addr steps 0..7.
2. Activations=-3, weights=5 for 8 vectors → result_data=0xFFFFFE20 (-480).
3. Enter EMIT with result_full_n=0 for 5 cycles → no enq and vec_deq=0 throughout. Raise full_n → result_enq pulses on the next cycle with correct data. Next sum starts at count=0.
4. Vectors from scenario 1 with vec_empty_n toggling every other cycle → count advances only on deq edges, weight_addr holds between deqs, result still 64.
5. Activations=weights=32767, 8 vectors, SHIFT=0 (true sum 34357641248) → 0x7FFFFFFF with VEC_DOT_ACCUM_SATURATE_EN, 0xFFE00020 without.
6. Send 3 vectors, drive rst_n=0 for one cycle, then run scenario 1 → result_data=64 (partial sum discarded), result_enq=0 during reset.
